// File: rtl/dr_encoder_tx.sv
// dr_encoder_tx -- dual-rail (four-phase, return-to-spacer) transmitter.
//
// A single-rail word accepted on the in_valid/in_ready handshake is driven
// as a dual-rail codeword (out_1 = word, out_0 = ~word). Once the receiver
// acknowledges (ack = 1), the spacer is driven. Once ack returns to 0, the
// block goes back to IDLE. Each phase is held for at least HOLD cycles. A
// receiver that stalls for TMO consecutive cycles sends the block to a
// sticky ERR state, and only reset leaves that state.
//
// Ports:
//   clk       in   clock, rising edge
//   reset     in   synchronous active-high reset
//   in_data   in   [WIDTH] word to transmit
//   in_valid  in   in_data valid
//   in_ready  out  word accepted this cycle (registered)
//   out_1     out  [WIDTH] true rails (registered)
//   out_0     out  [WIDTH] false rails (registered)
//   ack       in   receiver completion: 1 = codeword seen, 0 = spacer seen
//   busy      out  transfer in progress (DATA or RTS)
//   timeout   out  sticky ack-timeout flag
module dr_encoder_tx #(
  parameter int WIDTH  = 3,
  parameter bit SPACER = 1'b0,
  parameter int HOLD   = 1,
  parameter int TMO    = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_1,
  output logic [WIDTH-1:0] out_0,
  input  logic             ack,
  output logic             busy,
  output logic             timeout
);

  typedef enum logic [1:0] {IDLE, DATA, RTS, ERR} state_t;

  localparam logic [WIDTH-1:0] SP_WORD = SPACER ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
  localparam logic [4:0]       HOLD_L  = 5'(HOLD);
  localparam logic [7:0]       TMO_M1  = 8'(TMO - 1);

  state_t           state;
  logic [3:0]       phase_cnt;
  logic [7:0]       wait_cnt;
  logic [WIDTH-1:0] word;
  logic             phase_done;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  // phase_cnt holds the cycles already completed in the phase, so the
  // current cycle is number phase_cnt+1; the phase may end once that
  // reaches HOLD.
  assign phase_done = ({1'b0, phase_cnt} + 5'd1) >= HOLD_L;

  // in_ready is registered: it is raised for the cycle after an edge that
  // leaves the block in IDLE with ack low, so a receiver still holding ack
  // high keeps the handshake closed.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      phase_cnt <= 4'd0;
      wait_cnt  <= 8'd0;
      word      <= '0;
      out_1     <= SP_WORD;
      out_0     <= SP_WORD;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          phase_cnt <= 4'd0;
          wait_cnt  <= 8'd0;
          out_1     <= SP_WORD;
          out_0     <= SP_WORD;
          if (in_valid && in_ready) begin
            state    <= DATA;
            word     <= in_data;
            out_1    <= in_data;
            out_0    <= ~in_data;
            busy     <= 1'b1;
            in_ready <= 1'b0;
          end else begin
            in_ready <= ~ack;
          end
        end

        DATA: begin
          in_ready <= 1'b0;
          if (ack && phase_done) begin
            state     <= RTS;
            out_1     <= SP_WORD;
            out_0     <= SP_WORD;
            phase_cnt <= 4'd0;
            wait_cnt  <= 8'd0;
          end else if (wait_cnt == TMO_M1) begin
            state     <= ERR;
            out_1     <= SP_WORD;
            out_0     <= SP_WORD;
            busy      <= 1'b0;
            timeout   <= 1'b1;
            phase_cnt <= 4'd0;
            wait_cnt  <= 8'd0;
          end else begin
            out_1     <= word;
            out_0     <= ~word;
            phase_cnt <= sat_inc4(phase_cnt);
            wait_cnt  <= wait_cnt + 8'd1;
          end
        end

        RTS: begin
          out_1 <= SP_WORD;
          out_0 <= SP_WORD;
          if (!ack && phase_done) begin
            state     <= IDLE;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            phase_cnt <= 4'd0;
            wait_cnt  <= 8'd0;
          end else if (wait_cnt == TMO_M1) begin
            state     <= ERR;
            busy      <= 1'b0;
            in_ready  <= 1'b0;
            timeout   <= 1'b1;
            phase_cnt <= 4'd0;
            wait_cnt  <= 8'd0;
          end else begin
            in_ready  <= 1'b0;
            phase_cnt <= sat_inc4(phase_cnt);
            wait_cnt  <= wait_cnt + 8'd1;
          end
        end

        default: begin
          // ERR: parked on the spacer until reset.
          state    <= ERR;
          out_1    <= SP_WORD;
          out_0    <= SP_WORD;
          in_ready <= 1'b0;
          busy     <= 1'b0;
          timeout  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dr_encoder_tx.sv
module tb_dr_encoder_tx;

  logic clk;
  logic reset;

  // a: defaults (WIDTH=3, SPACER=0, HOLD=1, TMO=255)
  logic [2:0] a_data;  logic a_valid; logic a_ready; logic [2:0] a_o1; logic [2:0] a_o0;
  logic a_ack; logic a_busy; logic a_tmo;
  // b: SPACER=1
  logic [2:0] b_data;  logic b_valid; logic b_ready; logic [2:0] b_o1; logic [2:0] b_o0;
  logic b_ack; logic b_busy; logic b_tmo;
  // c: HOLD=4, TMO=20
  logic [2:0] c_data;  logic c_valid; logic c_ready; logic [2:0] c_o1; logic [2:0] c_o0;
  logic c_ack; logic c_busy; logic c_tmo;
  // d: TMO=10
  logic [2:0] d_data;  logic d_valid; logic d_ready; logic [2:0] d_o1; logic [2:0] d_o0;
  logic d_ack; logic d_busy; logic d_tmo;

  int checks;
  int failures;

  dr_encoder_tx #(.WIDTH(3), .SPACER(1'b0), .HOLD(1), .TMO(255)) dut_a (
    .clk(clk), .reset(reset), .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
    .out_1(a_o1), .out_0(a_o0), .ack(a_ack), .busy(a_busy), .timeout(a_tmo));

  dr_encoder_tx #(.WIDTH(3), .SPACER(1'b1), .HOLD(1), .TMO(255)) dut_b (
    .clk(clk), .reset(reset), .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
    .out_1(b_o1), .out_0(b_o0), .ack(b_ack), .busy(b_busy), .timeout(b_tmo));

  dr_encoder_tx #(.WIDTH(3), .SPACER(1'b0), .HOLD(4), .TMO(20)) dut_c (
    .clk(clk), .reset(reset), .in_data(c_data), .in_valid(c_valid), .in_ready(c_ready),
    .out_1(c_o1), .out_0(c_o0), .ack(c_ack), .busy(c_busy), .timeout(c_tmo));

  dr_encoder_tx #(.WIDTH(3), .SPACER(1'b0), .HOLD(1), .TMO(10)) dut_d (
    .clk(clk), .reset(reset), .in_data(d_data), .in_valid(d_valid), .in_ready(d_ready),
    .out_1(d_o1), .out_0(d_o0), .ack(d_ack), .busy(d_busy), .timeout(d_tmo));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    a_data = '0; a_valid = 1'b0; a_ack = 1'b0;
    b_data = '0; b_valid = 1'b0; b_ack = 1'b0;
    c_data = '0; c_valid = 1'b0; c_ack = 1'b0;
    d_data = '0; d_valid = 1'b0; d_ack = 1'b0;

    // Reset state
    tick();
    chk("rst_ready", a_ready, 0);
    chk("rst_o1", a_o1, 3'b000);
    chk("rst_o0", a_o0, 3'b000);
    chk("rst_busy", a_busy, 0);
    chk("rst_tmo", a_tmo, 0);
    chk("rst_b_o1", b_o1, 3'b111);
    chk("rst_b_o0", b_o0, 3'b111);
    reset = 1'b0;
    tick();
    chk("idle_ready", a_ready, 1);
    chk("idle_b_ready", b_ready, 1);

    // Basic transfer, SPACER=0, HOLD=1
    a_data = 3'b101; a_valid = 1'b1;
    tick();
    a_valid = 1'b0;
    chk("a_cw_o1", a_o1, 3'b101);
    chk("a_cw_o0", a_o0, 3'b010);
    chk("a_cw_busy", a_busy, 1);
    chk("a_cw_ready", a_ready, 0);
    a_ack = 1'b1;
    tick();
    chk("a_rts_o1", a_o1, 3'b000);
    chk("a_rts_o0", a_o0, 3'b000);
    chk("a_rts_busy", a_busy, 1);
    a_ack = 1'b0;
    tick();
    chk("a_idle_ready", a_ready, 1);
    chk("a_idle_busy", a_busy, 0);

    // Back-to-back second word: 3 cycles per word at HOLD=1
    a_data = 3'b110; a_valid = 1'b1;
    tick();
    a_valid = 1'b0;
    chk("a_cw2_o1", a_o1, 3'b110);
    chk("a_cw2_o0", a_o0, 3'b001);
    a_ack = 1'b1;
    tick();
    chk("a_rts2_o1", a_o1, 3'b000);
    a_ack = 1'b0;
    tick();
    chk("a_idle2_ready", a_ready, 1);

    // ack stuck high in IDLE: no accept, spacer stays
    a_ack = 1'b1;
    tick();
    chk("a_stuck_ready", a_ready, 0);
    a_data = 3'b011; a_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("a_stuck_ready_v", a_ready, 0);
      chk("a_stuck_o1", a_o1, 3'b000);
      chk("a_stuck_o0", a_o0, 3'b000);
      chk("a_stuck_busy", a_busy, 0);
    end
    a_valid = 1'b0; a_ack = 1'b0;
    tick();
    chk("a_unstuck_ready", a_ready, 1);

    // SPACER=1
    b_data = 3'b011; b_valid = 1'b1;
    tick();
    b_valid = 1'b0;
    chk("b_cw_o1", b_o1, 3'b011);
    chk("b_cw_o0", b_o0, 3'b100);
    b_ack = 1'b1;
    tick();
    chk("b_rts_o1", b_o1, 3'b111);
    chk("b_rts_o0", b_o0, 3'b111);
    chk("b_rts_busy", b_busy, 1);
    b_ack = 1'b0;
    tick();
    chk("b_idle_o1", b_o1, 3'b111);
    chk("b_idle_o0", b_o0, 3'b111);
    chk("b_idle_ready", b_ready, 1);

    // HOLD=4: ack high from the first DATA cycle, codeword held exactly 4 cycles
    tick();
    chk("c_idle_ready", c_ready, 1);
    c_data = 3'b101; c_valid = 1'b1;
    tick();
    c_valid = 1'b0;
    c_ack = 1'b1;
    chk("c_cw1_o1", c_o1, 3'b101);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("c_cw_hold_o1", c_o1, 3'b101);
      chk("c_cw_hold_o0", c_o0, 3'b010);
    end
    tick();
    chk("c_rts_o1", c_o1, 3'b000);
    chk("c_rts_o0", c_o0, 3'b000);
    chk("c_rts_busy", c_busy, 1);
    c_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("c_rts_hold_busy", c_busy, 1);
      chk("c_rts_hold_o1", c_o1, 3'b000);
      chk("c_rts_hold_ready", c_ready, 0);
    end
    tick();
    chk("c_idle_busy", c_busy, 0);
    chk("c_idle_ready2", c_ready, 1);
    chk("c_tmo", c_tmo, 0);

    // TMO=10: ack never comes
    d_data = 3'b111; d_valid = 1'b1;
    tick();
    d_valid = 1'b0;
    chk("d_cw_o1", d_o1, 3'b111);
    for (int i = 0; i < 9; i++) tick();
    chk("d_cw10_o1", d_o1, 3'b111);
    chk("d_cw10_tmo", d_tmo, 0);
    tick();
    chk("d_err_tmo", d_tmo, 1);
    chk("d_err_o1", d_o1, 3'b000);
    chk("d_err_o0", d_o0, 3'b000);
    chk("d_err_busy", d_busy, 0);
    chk("d_err_ready", d_ready, 0);
    d_data = 3'b010; d_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("d_err_hold_ready", d_ready, 0);
      chk("d_err_hold_o1", d_o1, 3'b000);
      chk("d_err_hold_tmo", d_tmo, 1);
    end
    d_valid = 1'b0;

    // Reset mid-DATA on a; also clears d's error
    a_data = 3'b100; a_valid = 1'b1;
    tick();
    a_valid = 1'b0;
    chk("a_pre_rst_o1", a_o1, 3'b100);
    reset = 1'b1;
    tick();
    chk("a_mid_rst_o1", a_o1, 3'b000);
    chk("a_mid_rst_o0", a_o0, 3'b000);
    chk("a_mid_rst_busy", a_busy, 0);
    chk("a_mid_rst_tmo", a_tmo, 0);
    chk("a_mid_rst_ready", a_ready, 0);
    chk("d_rst_tmo", d_tmo, 0);
    reset = 1'b0;
    tick();
    chk("a_post_rst_ready", a_ready, 1);
    chk("d_post_rst_ready", d_ready, 1);
    a_data = 3'b001; a_valid = 1'b1;
    tick();
    a_valid = 1'b0;
    chk("a_post_rst_o1", a_o1, 3'b001);
    chk("a_post_rst_o0", a_o0, 3'b110);
    chk("a_post_rst_busy", a_busy, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
